// File: rtl/id_ex_stage.sv
// id_ex_stage: decode -> execute pipeline register built as a 2-entry skid buffer.
// The main entry drives the out* ports directly; the skid entry absorbs one
// instruction when execute stalls, so inReady is a pure register (~skid valid).
// Optional feature macro: ID_EX_FWD_EN enables writeback forwarding into the
// captured and held operands. Without it the wb* ports are present but ignored.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              resetN,
    // decoded instruction from decode
    input  logic              inValid,
    input  logic [DATA_W-1:0] inPc,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] imm,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              regWriteIn,
    input  logic [DATA_W-1:0] busA,
    input  logic [DATA_W-1:0] busB,
    output logic              inReady,
    // writeback triple
    input  logic              wbWrite,
    input  logic [4:0]        wbPort,
    input  logic [DATA_W-1:0] wbBus,
    input  logic              flush,
    // execute side
    output logic              outValid,
    output logic [DATA_W-1:0] outPc,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB,
    output logic [DATA_W-1:0] outImm,
    output logic [4:0]        outRd,
    output logic [CTRL_W-1:0] outCtrl,
    output logic              outRegWrite,
    input  logic              outReady
);

    logic              in_fire;
    logic              out_fire;
    logic              main_free;
    logic              cap_rw;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [DATA_W-1:0] main_a_next;
    logic [DATA_W-1:0] main_b_next;
    logic [DATA_W-1:0] skid_a_next;
    logic [DATA_W-1:0] skid_b_next;

    logic              skid_valid_reg;
    logic [DATA_W-1:0] skid_pc_reg;
    logic [DATA_W-1:0] skid_a_reg;
    logic [DATA_W-1:0] skid_b_reg;
    logic [DATA_W-1:0] skid_imm_reg;
    logic [4:0]        skid_rd_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;
    logic              skid_rw_reg;

    assign in_fire   = inValid & inReady & ~flush;
    assign out_fire  = outValid & outReady;
    // main can take a new instruction if it is empty or its occupant leaves now
    assign main_free = ~outValid | out_fire;
    // x0 is never a real destination
    assign cap_rw    = regWriteIn & (rd != 5'd0);

`ifdef ID_EX_FWD_EN
    logic       wb_ok;
    logic [4:0] main_rs1_reg;
    logic [4:0] main_rs2_reg;
    logic [4:0] skid_rs1_reg;
    logic [4:0] skid_rs2_reg;

    assign wb_ok = wbWrite & (wbPort != 5'd0);

    // operands at capture take the writeback value when it targets the same source
    assign cap_a = (rs1 == 5'd0) ? '0 : ((wb_ok && wbPort == rs1) ? wbBus : busA);
    assign cap_b = (rs2 == 5'd0) ? '0 : ((wb_ok && wbPort == rs2) ? wbBus : busB);

    // held entries pick up writebacks to their sources while they wait
    assign main_a_next = (wb_ok && wbPort == main_rs1_reg) ? wbBus : outA;
    assign main_b_next = (wb_ok && wbPort == main_rs2_reg) ? wbBus : outB;
    assign skid_a_next = (wb_ok && wbPort == skid_rs1_reg) ? wbBus : skid_a_reg;
    assign skid_b_next = (wb_ok && wbPort == skid_rs2_reg) ? wbBus : skid_b_reg;

    // source register numbers follow their instruction through main and skid
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            main_rs1_reg <= 5'd0;
            main_rs2_reg <= 5'd0;
            skid_rs1_reg <= 5'd0;
            skid_rs2_reg <= 5'd0;
        end else if (!flush) begin
            if (out_fire && skid_valid_reg) begin
                main_rs1_reg <= skid_rs1_reg;
                main_rs2_reg <= skid_rs2_reg;
            end else if (main_free && in_fire) begin
                main_rs1_reg <= rs1;
                main_rs2_reg <= rs2;
            end
            if (in_fire && !main_free) begin
                skid_rs1_reg <= rs1;
                skid_rs2_reg <= rs2;
            end
        end
    end
`else
    logic unused_wb;

    assign cap_a       = (rs1 == 5'd0) ? '0 : busA;
    assign cap_b       = (rs2 == 5'd0) ? '0 : busB;
    assign main_a_next = outA;
    assign main_b_next = outB;
    assign skid_a_next = skid_a_reg;
    assign skid_b_next = skid_b_reg;
    assign unused_wb   = ^{wbWrite, wbPort, wbBus};
`endif

    // main entry: refill from skid first (FIFO order), else from input, else hold
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outValid    <= 1'b0;
            outPc       <= '0;
            outA        <= '0;
            outB        <= '0;
            outImm      <= '0;
            outRd       <= 5'd0;
            outCtrl     <= '0;
            outRegWrite <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (out_fire && skid_valid_reg) begin
            outValid    <= 1'b1;
            outPc       <= skid_pc_reg;
            outA        <= skid_a_next;
            outB        <= skid_b_next;
            outImm      <= skid_imm_reg;
            outRd       <= skid_rd_reg;
            outCtrl     <= skid_ctrl_reg;
            outRegWrite <= skid_rw_reg;
        end else if (main_free) begin
            if (in_fire) begin
                outValid    <= 1'b1;
                outPc       <= inPc;
                outA        <= cap_a;
                outB        <= cap_b;
                outImm      <= imm;
                outRd       <= rd;
                outCtrl     <= ctrl;
                outRegWrite <= cap_rw;
            end else begin
                outValid <= 1'b0;
            end
        end else begin
            outA <= main_a_next;
            outB <= main_b_next;
        end
    end

    // skid entry and inReady: skid fills only when main is occupied and staying
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_a_reg     <= '0;
            skid_b_reg     <= '0;
            skid_imm_reg   <= '0;
            skid_rd_reg    <= 5'd0;
            skid_ctrl_reg  <= '0;
            skid_rw_reg    <= 1'b0;
            inReady        <= 1'b1;
        end else if (flush) begin
            skid_valid_reg <= 1'b0;
            inReady        <= 1'b1;
        end else if (out_fire && skid_valid_reg) begin
            skid_valid_reg <= 1'b0;
            inReady        <= 1'b1;
        end else if (in_fire && !main_free) begin
            skid_valid_reg <= 1'b1;
            skid_pc_reg    <= inPc;
            skid_a_reg     <= cap_a;
            skid_b_reg     <= cap_b;
            skid_imm_reg   <= imm;
            skid_rd_reg    <= rd;
            skid_ctrl_reg  <= ctrl;
            skid_rw_reg    <= cap_rw;
            inReady        <= 1'b0;
        end else begin
            skid_a_reg <= skid_a_next;
            skid_b_reg <= skid_b_next;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the id_ex_stage skid buffer.
// Expected values for forwarding cases follow ID_EX_FWD_EN if it is defined.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              resetN;
    logic              inValid;
    logic [DATA_W-1:0] inPc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic              regWriteIn;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic              inReady;
    logic              wbWrite;
    logic [4:0]        wbPort;
    logic [DATA_W-1:0] wbBus;
    logic              flush;
    logic              outValid;
    logic [DATA_W-1:0] outPc;
    logic [DATA_W-1:0] outA;
    logic [DATA_W-1:0] outB;
    logic [DATA_W-1:0] outImm;
    logic [4:0]        outRd;
    logic [CTRL_W-1:0] outCtrl;
    logic              outRegWrite;
    logic              outReady;

    int check_count = 0;
    int pass_count  = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .resetN(resetN),
        .inValid(inValid), .inPc(inPc), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .ctrl(ctrl), .regWriteIn(regWriteIn),
        .busA(busA), .busB(busB), .inReady(inReady),
        .wbWrite(wbWrite), .wbPort(wbPort), .wbBus(wbBus), .flush(flush),
        .outValid(outValid), .outPc(outPc), .outA(outA), .outB(outB),
        .outImm(outImm), .outRd(outRd), .outCtrl(outCtrl),
        .outRegWrite(outRegWrite), .outReady(outReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else begin
            pass_count++;
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef ID_EX_FWD_EN
    localparam logic [31:0] EXP_FWD_B  = 32'hAB;
    localparam logic [31:0] EXP_HELD_A = 32'hCAFE;
`else
    localparam logic [31:0] EXP_FWD_B  = 32'h1;
    localparam logic [31:0] EXP_HELD_A = 32'h10;
`endif

    initial begin
        resetN = 1'b0; inValid = 1'b0; inPc = '0; rs1 = '0; rs2 = '0; rd = '0;
        imm = '0; ctrl = '0; regWriteIn = 1'b0; busA = '0; busB = '0;
        wbWrite = 1'b0; wbPort = '0; wbBus = '0; flush = 1'b0; outReady = 1'b0;

        // reset state
        tick();
        check("rst_outValid", outValid, 0);
        check("rst_inReady", inReady, 1);
        check("rst_outPc", outPc, 0);
        check("rst_outA", outA, 0);

        // single instruction, 1-cycle latency, rs2=0 and rd=0 forcing
        resetN = 1'b1; outReady = 1'b1; inValid = 1'b1;
        inPc = 32'h100; rs1 = 5'd3; busA = 32'h11; rs2 = 5'd0; busB = 32'h55;
        rd = 5'd0; regWriteIn = 1'b1; imm = 32'h7; ctrl = 8'h5A;
        tick();
        inValid = 1'b0;
        check("lat_outValid", outValid, 1);
        check("lat_outA", outA, 32'h11);
        check("lat_outB_rs0", outB, 0);
        check("lat_inReady", inReady, 1);
        check("lat_outPc", outPc, 32'h100);
        check("lat_rw_rd0", outRegWrite, 0);
        check("lat_imm", outImm, 32'h7);
        check("lat_ctrl", outCtrl, 8'h5A);
        tick();
        check("lat_drain", outValid, 0);

        // stall with three back-to-back inputs, then release
        outReady = 1'b0; inValid = 1'b1; rd = 5'd9; regWriteIn = 1'b1;
        inPc = 32'h0;
        tick();
        check("stall1_pc", outPc, 32'h0);
        check("stall1_inReady", inReady, 1);
        check("stall1_rd", outRd, 9);
        check("stall1_rw", outRegWrite, 1);
        inPc = 32'h4;
        tick();
        check("stall2_pc", outPc, 32'h0);
        check("stall2_inReady", inReady, 0);
        inPc = 32'h8;
        tick();
        check("stall3_pc", outPc, 32'h0);
        check("stall3_inReady", inReady, 0);
        outReady = 1'b1;
        tick();
        check("rel1_valid", outValid, 1);
        check("rel1_pc", outPc, 32'h4);
        check("rel1_inReady", inReady, 1);
        tick();
        inValid = 1'b0;
        check("rel2_valid", outValid, 1);
        check("rel2_pc", outPc, 32'h8);
        tick();
        check("rel3_empty", outValid, 0);

        // capture-time forwarding, back to back
        inValid = 1'b1; inPc = 32'h20; rs1 = 5'd0; rs2 = 5'd5; busB = 32'h1;
        wbWrite = 1'b1; wbPort = 5'd5; wbBus = 32'hAB;
        tick();
        check("cap_fwd_outB", outB, EXP_FWD_B);
        rs2 = 5'd0; busB = 32'h77; wbPort = 5'd0;
        tick();
        check("cap_rs0_outB", outB, 0);
        inValid = 1'b0; wbWrite = 1'b0;
        tick();
        check("cap_drain", outValid, 0);

        // held-entry update while stalled
        outReady = 1'b0; inValid = 1'b1; rs1 = 5'd7; busA = 32'h10; inPc = 32'h40;
        tick();
        check("held_before", outA, 32'h10);
        inValid = 1'b0; wbWrite = 1'b1; wbPort = 5'd7; wbBus = 32'hCAFE;
        tick();
        wbWrite = 1'b0;
        check("held_after_wb", outA, EXP_HELD_A);
        check("held_pc", outPc, 32'h40);
        outReady = 1'b1;
        tick();
        check("held_drain", outValid, 0);

        // flush with both entries full and a concurrent input
        outReady = 1'b0; inValid = 1'b1; inPc = 32'h200;
        tick();
        inPc = 32'h204;
        tick();
        check("fl_full", inReady, 0);
        flush = 1'b1; inPc = 32'h300;
        tick();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        check("fl_outValid", outValid, 0);
        check("fl_inReady", inReady, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_ghost", outValid, 0);
        end

        // asynchronous reset between edges during a stall
        outReady = 1'b0; inValid = 1'b1; inPc = 32'h500;
        tick();
        inPc = 32'h504;
        tick();
        inValid = 1'b0;
        check("ar_full_valid", outValid, 1);
        check("ar_full_ready", inReady, 0);
        #2;
        resetN = 1'b0;
        #1;
        check("ar_outValid", outValid, 0);
        check("ar_inReady", inReady, 1);
        check("ar_outPc", outPc, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/PC/immediate width.
REQ-002 SHALL have parameter CTRL_W, default 8, width of opaque execute-control bundle.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; one clock domain only.
REQ-004 SHALL have ports: resetN  in  1  reset, asynchronous assert and active-low.
REQ-005 SHALL have inputs inValid(1), inPc(DATA_W), rs1(5), rs2(5), rd(5), imm(DATA_W), ctrl(CTRL_W), regWriteIn(1): the decoded instruction.
REQ-006 SHALL have inputs busA(DATA_W), busB(DATA_W): register-bank read data for rs1/rs2 (same cycle).
REQ-007 SHALL have output inReady(1), registered; decode SHALL hold its inputs while inValid=1 and inReady=0.
REQ-008 SHALL have inputs wbWrite(1), wbPort(5), wbBus(DATA_W): the writeback triple that also drives the register bank.
REQ-009 SHALL have input flush(1): synchronous kill of all held and incoming instructions.
REQ-010 SHALL have outputs outValid(1), outPc, outA, outB, outImm (DATA_W), outRd(5), outCtrl(CTRL_W), outRegWrite(1); input outReady(1) from execute.

Function
REQ-011 SHALL be a 2-entry skid buffer: main entry drives out*, skid entry holds one overflow instruction.
REQ-012 Input transfer SHALL occur on a rising edge with inValid=1, inReady=1, flush=0; output transfer SHALL occur on a rising edge with outValid=1, outReady=1.
REQ-013 inReady SHALL equal "skid entry empty", registered; combinational paths from outReady to inReady are forbidden.
REQ-014 Captured instruction SHALL go to main if main empty or main is leaving this edge (and skid empty), else to skid.
REQ-015 When main leaves and skid is full, skid SHALL move to main on the same edge; order SHALL be preserved (FIFO).
REQ-016 Latency input transfer -> outValid SHALL be exactly 1 cycle when main is empty; throughput 1 instruction/cycle when outReady held 1.
REQ-017 Operand for rs=0 SHALL be captured as 0 regardless of busA/busB or writeback.
REQ-018 outRd and outRegWrite SHALL be captured unchanged; outRegWrite for rd=0 SHALL be forced to 0.
REQ-019 flush=1 SHALL clear main and skid valid on that edge, discard any concurrent input, and give inReady=1 next cycle; flush has priority over every transfer.
REQ-020 out* data fields SHALL hold their value while outValid=1 and outReady=0, except as modified by REQ-023.
REQ-021 Data fields of an invalid entry are don't-care; outValid SHALL never glitch to 1 except after a valid capture.

Reset
REQ-022 resetN=0 SHALL asynchronously clear main/skid valid, all out* data to 0, outValid=0, inReady=1; first capture on the first edge after resetN rises.

Configuration
REQ-023 Macro ID_EX_FWD_EN, when defined: at capture, operand = wbBus if wbWrite=1, wbPort!=0, wbPort==rs, else busA/busB; every held valid entry (main and skid) whose rs1/rs2 equals wbPort with wbWrite=1, wbPort!=0 SHALL update that operand to wbBus on the same edge.
REQ-024 When ID_EX_FWD_EN is undefined: operands SHALL be captured raw from busA/busB and never updated while held; no wb* logic synthesised (ports remain, ignored).

Verification
REQ-025 Reset then rs1=3,busA=0x11,inValid=1, outReady=1 -> outValid=1 next cycle with outA=0x11, inReady stays 1.
REQ-026 outReady=0, three back-to-back inputs PC 0x0,0x4,0x8 -> main=0x0, skid=0x4, inReady=0 after 2nd edge, 0x8 held; release outReady -> PCs exit 0x0,0x4,0x8 in order, no loss/duplicate.
REQ-027 FWD_EN: capture rs2=5,busB=0x1 with wbWrite=1,wbPort=5,wbBus=0xAB -> outB=0xAB; same with wbPort=0 and rs2=0 -> outB=0.
REQ-028 FWD_EN: main holds rs1=7 stalled (outReady=0), write wbPort=7,wbBus=0xCAFE -> outA=0xCAFE next cycle; without macro outA unchanged.
REQ-029 Both entries full, flush=1 with inValid=1 -> next cycle outValid=0, inReady=1, flushed and concurrent instructions never appear.
REQ-030 Assert resetN=0 mid-stall between clock edges -> outValid=0, inReady=1 immediately, before next clk edge.
